exe_mem_stage: RTL and testbench
================================

Name: exe_mem_stage

Overview:
- Sits directly downstream of the ID/EXE register and ALU.
- Latches the EXE-stage result as the EXE/MEM pipeline register.
- Performs lw/sw through a req/ack data-memory handshake and presents the final GPR writeback triple to WB.
- Raises mem_busy so PipelineController freezes upstream stages while a memory access is outstanding; includes alignment and ack-timeout checking.

Parameters:
- TIMEOUT_CYCLES, 255: maximum REQ cycles without dmem_ack before the access is abandoned. Legal range 1..65535.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- ena  in  1  capture enable from PipelineController.exe_mem_ena
- flush  in  1  capture a bubble instead of the EXE contents
- exe_op  in  6  instr[31:26] of the EXE instruction
- exe_alu_result  in  32  ALU output
- exe_mem_fetch_addr  in  32  effective address for lw/sw
- exe_GPR_rt_in  in  32  store data
- exe_GPR_we  in  1  GPR write enable
- exe_GPR_waddr  in  5  GPR destination
- exe_GPR_wdata_select  in  2  00 ALU, 01 load data, 10 pc+8, 11 ALU
- exe_pc_in  in  32  instruction PC
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, bits[1:0] always 0
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid with ack
- dmem_ack  in  1  access complete
- mem_busy  out  1  stall request to PipelineController
- mem_err  out  1  one-cycle pulse: misaligned access or timeout
- mem_GPR_we  out  1  writeback enable
- mem_GPR_waddr  out  5  writeback address
- mem_GPR_wdata  out  32  writeback data
- mem_pc_out  out  32  PC forwarded to WB

Behaviour:
- Reset: all registers and outputs go to 0 and state goes to IDLE. Reset has priority at any time, including in REQ; dmem_req drops the cycle after the reset edge and no writeback occurs.
- Capture: registers load at a posedge only when ena=1 and state=IDLE. When ena=0, or state=REQ, all contents hold.
- flush=1 at capture loads a bubble (we=0, op=0, other fields 0), overriding exe_*. flush is ignored when no capture occurs.
- Memory op: captured op is 6'b100011 (lw) or 6'b101011 (sw).
  - If exe_mem_fetch_addr[1:0]==0, state goes IDLE->REQ on the capture edge.
  - If misaligned, state stays IDLE, mem_err pulses 1 in the following cycle, and the captured GPR_we is forced 0.
- Non-memory ops: 0 extra latency. Outputs are valid in the cycle after capture.
- States:
  - IDLE: dmem_req=0, mem_busy=0.
  - REQ: dmem_req=1, mem_busy=1. dmem_we, dmem_addr and dmem_wdata are held stable from the latched fields. dmem_addr = {addr[31:2],2'b00}.
- In REQ, a posedge with dmem_ack=1 latches dmem_rdata (lw) into the load register and returns to IDLE. Minimum lw/sw latency is 2 cycles from capture to mem_busy=0.
- Timeout counter: zeroed on entry to REQ and incremented each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES-1 without ack, the next edge goes to IDLE, mem_err pulses, and GPR_we is forced 0.
  - An ack on that same edge wins: normal completion, no error.
- dmem_ack while in IDLE is ignored.
- mem_GPR_wdata is chosen by the latched select:
  - 01: load register.
  - 10: pc+8, mod 2^32 wrap, so 32'hFFFFFFFC gives 32'h00000004.
  - otherwise: alu_result.
- mem_GPR_we = latched we & ~mem_busy, so WB never writes stale data during REQ. sw normally arrives with we=0; if we=1 it is honoured after completion.
- mem_GPR_waddr and mem_pc_out are direct register outputs.
- mem_err is never 1 for two consecutive cycles unless two faulting instructions are captured back-to-back.

Test Plan:
- Reset, then ena=1 with an addu: alu_result=32'h12345678, we=1, waddr=5, sel=00 -> next cycle mem_GPR_we=1, waddr=5, wdata=32'h12345678, mem_busy=0, dmem_req=0.
- lw with addr=32'h00000104, sel=01, waddr=8; ack returns 3 cycles later with rdata=32'hDEADBEEF -> dmem_req=1 and dmem_addr=32'h00000104 for 3 cycles, mem_busy=1 and mem_GPR_we=0 throughout, then wdata=32'hDEADBEEF with we=1. A new EXE instruction presented during REQ is not captured.
- sw with addr=32'h00000200 and rt=32'hA5A5A5A5, ack in the first REQ cycle -> exactly one cycle with dmem_req=1, dmem_we=1, dmem_wdata=32'hA5A5A5A5; no GPR write.
- lw with addr=32'h00000102 -> no dmem_req, mem_err=1 for one cycle, mem_GPR_we=0.
- TIMEOUT_CYCLES=4 with no ack -> dmem_req high for exactly 4 cycles, then mem_err pulse and IDLE. Repeat with ack on the 4th cycle -> no error, normal writeback.
- Assert reset low during REQ -> next cycle dmem_req=0, mem_busy=0, all outputs 0. Separately, flush=1 together with ena=1 on an lw -> bubble captured and no dmem_req.
- jal-type capture: sel=10, pc=32'hFFFFFFFC -> wdata=32'h00000004.

Source files
------------

// File: rtl/exe_mem_stage.sv
// EXE/MEM pipeline register with a req/ack data-memory port for lw/sw.
// Holds the pipeline (mem_busy) while an access is outstanding and flags misaligned or timed-out accesses.
module exe_mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic        flush,
  input  logic [5:0]  exe_op,
  input  logic [31:0] exe_alu_result,
  input  logic [31:0] exe_mem_fetch_addr,
  input  logic [31:0] exe_GPR_rt_in,
  input  logic        exe_GPR_we,
  input  logic [4:0]  exe_GPR_waddr,
  input  logic [1:0]  exe_GPR_wdata_select,
  input  logic [31:0] exe_pc_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_busy,
  output logic        mem_err,
  output logic        mem_GPR_we,
  output logic [4:0]  mem_GPR_waddr,
  output logic [31:0] mem_GPR_wdata,
  output logic [31:0] mem_pc_out
);

  localparam logic [5:0]  OP_LW        = 6'b100011;
  localparam logic [5:0]  OP_SW        = 6'b101011;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Only the word address is kept; the byte offset is checked at capture and never used again.
  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] alu_result;
    logic [29:0] addr_word;
    logic [31:0] rt;
    logic        we;
    logic [4:0]  waddr;
    logic [1:0]  wdata_select;
    logic [31:0] pc;
  } exe_mem_t;

  state_t      state_q, state_d;
  exe_mem_t    pipe_q, pipe_d;
  logic [31:0] load_q, load_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        err_q, err_d;

  logic is_mem_op;
  logic aligned;

  assign is_mem_op = (exe_op == OP_LW) || (exe_op == OP_SW);
  assign aligned   = (exe_mem_fetch_addr[1:0] == 2'b00);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    pipe_d  = pipe_q;
    load_d  = load_q;
    tcnt_d  = tcnt_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ena) begin
          if (flush) begin
            pipe_d = '0;
          end else begin
            pipe_d.op           = exe_op;
            pipe_d.alu_result   = exe_alu_result;
            pipe_d.addr_word    = exe_mem_fetch_addr[31:2];
            pipe_d.rt           = exe_GPR_rt_in;
            pipe_d.we           = exe_GPR_we;
            pipe_d.waddr        = exe_GPR_waddr;
            pipe_d.wdata_select = exe_GPR_wdata_select;
            pipe_d.pc           = exe_pc_in;
            if (is_mem_op) begin
              if (aligned) begin
                state_d = REQ;
                tcnt_d  = '0;
              end else begin
                // A faulting access never reaches memory and must not write a GPR.
                pipe_d.we = 1'b0;
                err_d     = 1'b1;
              end
            end
          end
        end
      end

      REQ: begin
        // An ack on the final allowed cycle still counts as a normal completion.
        if (dmem_ack) begin
          if (pipe_q.op == OP_LW) begin
            load_d = dmem_rdata;
          end
          state_d = IDLE;
        end else if (tcnt_q == TIMEOUT_LAST) begin
          state_d   = IDLE;
          pipe_d.we = 1'b0;
          err_d     = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q <= IDLE;
      pipe_q  <= '0;
      load_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
      load_q  <= load_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  assign dmem_req   = (state_q == REQ);
  assign mem_busy   = (state_q == REQ);
  assign dmem_we    = dmem_req && (pipe_q.op == OP_SW);
  assign dmem_addr  = {pipe_q.addr_word, 2'b00};
  assign dmem_wdata = pipe_q.rt;
  assign mem_err    = err_q;

  // Writeback is masked while busy so WB never sees a load result before it arrives.
  assign mem_GPR_we    = pipe_q.we & ~mem_busy;
  assign mem_GPR_waddr = pipe_q.waddr;
  assign mem_pc_out    = pipe_q.pc;

  always_comb begin
    mem_GPR_wdata = pipe_q.alu_result;
    unique case (pipe_q.wdata_select)
      2'b01:   mem_GPR_wdata = load_q;
      2'b10:   mem_GPR_wdata = pipe_q.pc + 32'd8;
      default: mem_GPR_wdata = pipe_q.alu_result;
    endcase
  end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed and randomized bench for exe_mem_stage, built with a short ack timeout of 4 cycles.
module tb_exe_mem_stage;

  localparam int TO = 4;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  logic        clk = 1'b0;
  logic        reset;
  logic        ena;
  logic        flush;
  logic [5:0]  exe_op;
  logic [31:0] exe_alu_result;
  logic [31:0] exe_mem_fetch_addr;
  logic [31:0] exe_GPR_rt_in;
  logic        exe_GPR_we;
  logic [4:0]  exe_GPR_waddr;
  logic [1:0]  exe_GPR_wdata_select;
  logic [31:0] exe_pc_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        mem_busy;
  logic        mem_err;
  logic        mem_GPR_we;
  logic [4:0]  mem_GPR_waddr;
  logic [31:0] mem_GPR_wdata;
  logic [31:0] mem_pc_out;

  exe_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                  (clk),
    .reset                (reset),
    .ena                  (ena),
    .flush                (flush),
    .exe_op               (exe_op),
    .exe_alu_result       (exe_alu_result),
    .exe_mem_fetch_addr   (exe_mem_fetch_addr),
    .exe_GPR_rt_in        (exe_GPR_rt_in),
    .exe_GPR_we           (exe_GPR_we),
    .exe_GPR_waddr        (exe_GPR_waddr),
    .exe_GPR_wdata_select (exe_GPR_wdata_select),
    .exe_pc_in            (exe_pc_in),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_rdata           (dmem_rdata),
    .dmem_ack             (dmem_ack),
    .mem_busy             (mem_busy),
    .mem_err              (mem_err),
    .mem_GPR_we           (mem_GPR_we),
    .mem_GPR_waddr        (mem_GPR_waddr),
    .mem_GPR_wdata        (mem_GPR_wdata),
    .mem_pc_out           (mem_pc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] alu;
    logic [31:0] addr;
    logic [31:0] rt;
    logic        we;
    logic [4:0]  waddr;
    logic [1:0]  sel;
    logic [31:0] pc;
    logic        flush;
  } instr_t;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] load_reg = 32'd0;  // the last word a completed lw returned

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_junk();
    exe_op               = 6'($urandom);
    exe_alu_result       = $urandom;
    exe_mem_fetch_addr   = $urandom;
    exe_GPR_rt_in        = $urandom;
    exe_GPR_we           = 1'($urandom);
    exe_GPR_waddr        = 5'($urandom);
    exe_GPR_wdata_select = 2'($urandom);
    exe_pc_in            = $urandom;
  endtask

  function automatic instr_t mk(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] addr,
                                input logic [31:0] rt, input logic we, input logic [4:0] waddr,
                                input logic [1:0] sel, input logic [31:0] pc, input logic fl);
    instr_t i;
    i.op = op; i.alu = alu; i.addr = addr; i.rt = rt; i.we = we;
    i.waddr = waddr; i.sel = sel; i.pc = pc; i.flush = fl;
    return i;
  endfunction

  // Presents one instruction, serves the memory side (ack on REQ cycle ack_at, 0 = never),
  // then compares the writeback triple against what the instruction should produce.
  task automatic do_instr(input string nm, input instr_t in, input int ack_at, input logic [31:0] rdata);
    bit          is_mem, aligned, acked, exp_err;
    int          n;
    logic [31:0] exp_wdata;
    logic        exp_we;
    exe_op               = in.op;
    exe_alu_result       = in.alu;
    exe_mem_fetch_addr   = in.addr;
    exe_GPR_rt_in        = in.rt;
    exe_GPR_we           = in.we;
    exe_GPR_waddr        = in.waddr;
    exe_GPR_wdata_select = in.sel;
    exe_pc_in            = in.pc;
    flush = in.flush;
    ena   = 1'b1;
    @(posedge clk); #1;
    ena   = 1'b0;
    flush = 1'b0;

    is_mem  = !in.flush && (in.op == OP_LW || in.op == OP_SW);
    aligned = (in.addr[1:0] == 2'b00);
    acked   = 1'b0;
    if (is_mem && aligned) begin
      n = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
      for (int k = 1; k <= n; k++) begin
        check({nm, ".req"},   32'(dmem_req), 32'd1);
        check({nm, ".busy"},  32'(mem_busy), 32'd1);
        check({nm, ".gwe_busy"}, 32'(mem_GPR_we), 32'd0);
        check({nm, ".daddr"}, dmem_addr, {in.addr[31:2], 2'b00});
        check({nm, ".dwe"},   32'(dmem_we), 32'(in.op == OP_SW));
        check({nm, ".dwdata"}, dmem_wdata, in.rt);
        // A competing instruction offered mid-access must be ignored.
        drive_junk();
        ena        = 1'b1;
        flush      = 1'($urandom);
        dmem_ack   = (k == ack_at);
        dmem_rdata = (k == ack_at) ? rdata : $urandom;
        @(posedge clk); #1;
        ena      = 1'b0;
        flush    = 1'b0;
        dmem_ack = 1'b0;
      end
      acked = (ack_at >= 1 && ack_at <= TO);
      if (acked && in.op == OP_LW) load_reg = rdata;
    end

    exp_err = is_mem && (!aligned || !acked);
    exp_we  = !in.flush && in.we && !exp_err;
    if (in.flush)          exp_wdata = 32'd0;
    else if (in.sel == 2'b01) exp_wdata = load_reg;
    else if (in.sel == 2'b10) exp_wdata = in.pc + 32'd8;
    else                   exp_wdata = in.alu;

    check({nm, ".req_done"}, 32'(dmem_req), 32'd0);
    check({nm, ".busy_done"}, 32'(mem_busy), 32'd0);
    check({nm, ".err"},   32'(mem_err), 32'(exp_err));
    check({nm, ".gwe"},   32'(mem_GPR_we), 32'(exp_we));
    check({nm, ".gwaddr"}, 32'(mem_GPR_waddr), in.flush ? 32'd0 : 32'(in.waddr));
    check({nm, ".gwdata"}, mem_GPR_wdata, exp_wdata);
    check({nm, ".pc"},    mem_pc_out, in.flush ? 32'd0 : in.pc);

    // A stray ack while idle changes nothing; the error pulse lasts one cycle.
    dmem_ack   = 1'($urandom);
    dmem_rdata = $urandom;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check({nm, ".err_clr"}, 32'(mem_err), 32'd0);
    check({nm, ".req_idle"}, 32'(dmem_req), 32'd0);
    check({nm, ".gwdata_hold"}, mem_GPR_wdata, exp_wdata);
    check({nm, ".gwe_hold"}, 32'(mem_GPR_we), 32'(exp_we));
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, ".req"},    32'(dmem_req), 32'd0);
    check({nm, ".busy"},   32'(mem_busy), 32'd0);
    check({nm, ".dwe"},    32'(dmem_we), 32'd0);
    check({nm, ".daddr"},  dmem_addr, 32'd0);
    check({nm, ".dwdata"}, dmem_wdata, 32'd0);
    check({nm, ".err"},    32'(mem_err), 32'd0);
    check({nm, ".gwe"},    32'(mem_GPR_we), 32'd0);
    check({nm, ".gwaddr"}, 32'(mem_GPR_waddr), 32'd0);
    check({nm, ".gwdata"}, mem_GPR_wdata, 32'd0);
    check({nm, ".pc"},     mem_pc_out, 32'd0);
  endtask

  initial begin
    instr_t      in;
    logic [5:0]  rop;
    logic [31:0] raddr;

    reset = 1'b0; ena = 1'b0; flush = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    drive_junk();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    do_instr("addu", mk(6'b000000, 32'h12345678, 32'h0, 32'h0, 1'b1, 5'd5, 2'b00, 32'h00000040, 1'b0), 0, 32'h0);
    do_instr("lw",   mk(OP_LW, 32'h00000104, 32'h00000104, 32'h0, 1'b1, 5'd8, 2'b01, 32'h00000044, 1'b0),
             3, 32'hDEADBEEF);
    do_instr("sw",   mk(OP_SW, 32'h00000200, 32'h00000200, 32'hA5A5A5A5, 1'b0, 5'd0, 2'b00, 32'h00000048, 1'b0),
             1, 32'h0);
    do_instr("lw_mis", mk(OP_LW, 32'h00000102, 32'h00000102, 32'h0, 1'b1, 5'd9, 2'b01, 32'h0000004C, 1'b0),
             1, 32'h11111111);
    do_instr("lw_to", mk(OP_LW, 32'h00000300, 32'h00000300, 32'h0, 1'b1, 5'd10, 2'b01, 32'h00000050, 1'b0),
             0, 32'h0);
    do_instr("lw_ack4", mk(OP_LW, 32'h00000304, 32'h00000304, 32'h0, 1'b1, 5'd11, 2'b01, 32'h00000054, 1'b0),
             4, 32'hCAFEF00D);
    do_instr("sw_we", mk(OP_SW, 32'h0000FF00, 32'h00000400, 32'h01234567, 1'b1, 5'd12, 2'b00, 32'h00000058, 1'b0),
             2, 32'h0);
    do_instr("jal",  mk(6'b000011, 32'h0, 32'h0, 32'h0, 1'b1, 5'd31, 2'b10, 32'hFFFFFFFC, 1'b0), 0, 32'h0);
    do_instr("flush", mk(OP_LW, 32'h77777777, 32'h00000500, 32'h0, 1'b1, 5'd13, 2'b01, 32'h0000005C, 1'b1),
             1, 32'h22222222);
    do_instr("mis_a", mk(OP_SW, 32'h0, 32'h00000603, 32'h9, 1'b1, 5'd14, 2'b00, 32'h60, 1'b0), 1, 32'h0);

    // Reset while an access is outstanding.
    exe_op = OP_LW; exe_mem_fetch_addr = 32'h00000700; exe_GPR_we = 1'b1;
    exe_GPR_waddr = 5'd15; exe_GPR_wdata_select = 2'b01; exe_pc_in = 32'h00000064;
    ena = 1'b1;
    @(posedge clk); #1;
    ena = 1'b0;
    check("rst_req.pre", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("rst_req");
    reset    = 1'b1;
    load_reg = 32'd0;
    @(posedge clk); #1;
    do_instr("post_rst", mk(6'b001001, 32'h0BADF00D, 32'h0, 32'h0, 1'b1, 5'd16, 2'b01, 32'h68, 1'b0), 0, 32'h0);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0:       rop = OP_LW;
        1:       rop = OP_SW;
        2:       rop = 6'b000000;
        default: rop = 6'($urandom);
      endcase
      raddr = $urandom;
      if ($urandom_range(0, 3) != 0) raddr[1:0] = 2'b00;
      in = mk(rop, $urandom, raddr, $urandom, 1'($urandom), 5'($urandom), 2'($urandom), $urandom,
              $urandom_range(0, 7) == 0);
      do_instr("rand", in, $urandom_range(0, TO + 1), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
